multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I control FSM that sequences the shared datapath.
- The datapath comprises one memory port, instruction register, ALU with ALUOut register, and register file.
- Consumes instruction fields (OP, funct3, OPb5) from the instruction-field decoder, plus ALU flags and memory ready.
- Drives every datapath mux select and enable, and keeps a retired-instruction counter and a trap status.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- TIMEOUT, 16: maximum cycles allowed waiting on mem_ready. 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- OP  in  7  opcode instr[6:0]
- funct3  in  3  instr[14:12]
- OPb5  in  1  instr[5]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC from result
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded, 11 = pass B
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU direct
- retire  out  1  one-cycle pulse per completed instruction
- instr_cnt  out  CNT_W  retired-instruction count
- trap  out  1  sticky halt flag
- trap_cause  out  2  01 = illegal opcode, 10 = illegal branch funct3, 11 = memory timeout
- state_o  out  4  current state encoding

Behaviour:
- Synchronous reset:
  - state = FETCH, instr_cnt = 0, trap = 0, trap_cause = 00, wait counter = 0.
  - While rst = 1, all combinational outputs are forced to 0.
  - Reset mid-operation abandons any pending memory request; the next cycle is FETCH.
- Default output value is 0; each state asserts only the signals listed.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, UPPER=12, TRAP=15.
- FETCH:
  - Asserts mem_req, adr_src=0.
  - When mem_ready=1, same cycle: ir_write=1, pc_write=1, a=00, b=10, op=00, result_src=10; next state DECODE.
  - Otherwise stays in FETCH with ir_write=0, pc_write=0.
- DECODE: a=01, b=01, op=00 (branch/JAL target into ALUOut). Next state by OP:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 or 0010111 -> UPPER
  - any other value -> TRAP, cause 01
- MEMADR: a=10, b=01, op=00. Next state MEMWRITE if OPb5=1, else MEMREAD.
- MEMREAD: mem_req, adr_src=1. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1. Waits for mem_ready, then FETCH.
- EXECR: a=10, b=00, op=10. Next state ALUWB.
- EXECI: a=10, b=01, op=10. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH:
  - a=10, b=00, op=01, result_src=00. Next state FETCH.
  - pc_write = taken, where taken by funct3 is: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - funct3 010 or 011 -> TRAP, cause 10, with no pc_write.
- JALR: a=10, b=01, op=00 (ALUOut = rs1+imm). Next state JAL.
- JAL: a=01, b=10, op=00, result_src=00, pc_write=1 (PC = ALUOut target; ALU computes oldPC+4). Next state ALUWB.
- UPPER: b=01. OPb5=1 (LUI): op=11. OPb5=0 (AUIPC): a=01, op=00. Next state ALUWB.
- TRAP:
  - trap=1; trap_cause holds its value.
  - All other outputs are 0.
  - Exits only on rst.
- Retire:
  - retire=1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - instr_cnt increments by 1 on the same edge and wraps modulo 2^CNT_W.
- Memory timeout:
  - The wait counter increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - It clears when the state is left.
  - With TIMEOUT>0, reaching TIMEOUT consecutive waiting cycles sends the FSM to TRAP, cause 11.
  - mem_ready=1 on the TIMEOUT-th cycle wins; no trap is taken.

Test Plan:
- Reset, then R-type OP=0110011 with mem_ready=1 in FETCH -> states 0,1,6,8,0; reg_write=1 only in ALUWB; instr_cnt=1; retire is a single pulse.
- Load OP=0000011 with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles; MEMWB result_src=01; total 8 cycles; no trap.
- BEQ with zero=1 -> pc_write=1 in BRANCH. BNE with zero=1 -> pc_write=0. funct3=010 -> trap=1, trap_cause=10, FSM stuck at 15 until rst.
- JALR -> states 1,11,10,8,0; pc_write=1 in JAL and FETCH only; reg_write=1 in ALUWB.
- OP=1111111 -> TRAP, cause 01. Separately, mem_ready held 0 in FETCH -> TRAP cause 11 after 16 cycles; rst asserted mid-MEMWRITE -> next state FETCH, mem_write=0.
- LUI (OPb5=1) -> alu_op=11 in UPPER; AUIPC -> alu_src_a=01, alu_op=00. With CNT_W=4, 16 retired instructions -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared memory/IR/ALU/regfile datapath,
// counts retired instructions and latches a sticky trap with its cause.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       OP,
    input  logic [2:0]       funct3,
    input  logic             OPb5,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_UPPER    = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [3:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_cause;

    logic [3:0] w_next;
    logic [1:0] w_cause;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_retire;

    assign w_timeout = (TIMEOUT > 0) && (r_wait == WAIT_LAST);

    always_comb begin
        w_next     = r_state;
        w_cause    = 2'b00;
        w_waiting  = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    w_next     = S_DECODE;
                end else begin
                    w_waiting = 1'b1;
                    if (w_timeout) begin
                        w_next  = S_TRAP;
                        w_cause = 2'b11;
                    end
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (OP)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR;
                    7'b0110111, 7'b0010111: w_next = S_UPPER;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = OPb5 ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = (r_state == S_MEMWRITE);
                adr_src   = 1'b1;
                if (mem_ready) begin
                    w_next = (r_state == S_MEMWRITE) ? S_FETCH : S_MEMWB;
                end else begin
                    w_waiting = 1'b1;
                    if (w_timeout) begin
                        w_next  = S_TRAP;
                        w_cause = 2'b11;
                    end
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_next    = S_FETCH;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = ~zero;
                    3'b100:  pc_write = lt;
                    3'b101:  pc_write = ~lt;
                    3'b110:  pc_write = ltu;
                    3'b111:  pc_write = ~ltu;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = 2'b10;
                    end
                endcase
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_JAL;
            end
            // PC takes the target already in ALUOut while the ALU forms the link value
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_UPPER: begin
                alu_src_b = 2'b01;
                if (OPb5) alu_op = 2'b11;
                else      alu_src_a = 2'b01;
                w_next = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase

        w_retire = (w_next == S_FETCH) &&
                   ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                    (r_state == S_ALUWB) || (r_state == S_BRANCH));
        retire   = w_retire;
        trap     = (r_state == S_TRAP);

        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            retire     = 1'b0;
            trap       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_cnt   <= '0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_waiting && (w_next == r_state)) ? r_wait + WAIT_W'(1) : '0;
            if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) r_cause <= w_cause;
        end
    end

    assign instr_cnt  = r_cnt;
    assign trap_cause = r_cause;
    assign state_o    = r_state;

endmodule
